// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch stage with a direct-mapped, one-word-per-line
//            instruction cache.
//
// Holds the program counter, serves cache hits with one instruction per
// cycle, and on a miss raises a word request to mem_ctrl. When the word
// arrives, the line is filled and the word is forwarded. A branch redirect
// from EX has top priority and discards any fetch that is in flight.
//
// Ports
//   clk_in            clock
//   rst_in            asynchronous reset, active low
//   rdy_in            global ready; low freezes every register and the cache
//   stall_in          IF/ID cannot take a new instruction
//   branch_en_in      redirect request from EX
//   branch_target_in  redirect PC (low two bits ignored)
//   mc_if_req_out     word request to mem_ctrl, high while fetching
//   mc_inst_addr_out  word address to mem_ctrl (the current PC)
//   mc_inst_done_in   one-cycle completion pulse from mem_ctrl
//   mc_inst_in        fetched word, valid with mc_inst_done_in
//   if_valid_out      if_pc_out / if_inst_out hold a valid instruction
//   if_pc_out         PC of the output instruction
//   if_inst_out       output instruction
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter int          ICACHE_IDX_W = 7,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        branch_en_in,
  input  logic [31:0] branch_target_in,
  output logic        mc_if_req_out,
  output logic [31:0] mc_inst_addr_out,
  input  logic        mc_inst_done_in,
  input  logic [31:0] mc_inst_in,
  output logic        if_valid_out,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_inst_out
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;

  // Valid bits live in flops so reset can clear them all at once; tag and
  // data arrays carry no reset and are only trusted behind a valid bit.
  logic [LINES-1:0] line_vld_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    stalled;
  logic                    fill_en;
  logic [31:0]             target_aligned;

  assign idx            = pc_q[ICACHE_IDX_W+1:2];
  assign tag            = pc_q[31:ICACHE_IDX_W+2];
  assign hit            = line_vld_q[idx] && (tag_mem[idx] == tag);
  // An empty output slot is always fillable, so a stall only bites when
  // there is a valid instruction waiting to be taken.
  assign stalled        = stall_in && valid_q;
  assign target_aligned = branch_target_in & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    inst_out_d = inst_out_q;
    fill_en    = 1'b0;

    if (rdy_in) begin
      if (branch_en_in) begin
        // Returning to IDLE drops the request for at least one cycle, which
        // is what tells mem_ctrl to abandon the partial word.
        pc_d    = target_aligned;
        valid_d = 1'b0;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!stalled) begin
              if (hit) begin
                valid_d    = 1'b1;
                pc_out_d   = pc_q;
                inst_out_d = data_mem[idx];
                pc_d       = pc_q + 32'd4;
              end else begin
                valid_d = 1'b0;
                state_d = FETCH;
              end
            end
          end
          FETCH: begin
            if (mc_inst_done_in) begin
              fill_en = 1'b1;
              state_d = IDLE;
              // Forward the word directly; if stalled the line is still
              // filled and the word is re-read as a hit later.
              if (!stalled) begin
                valid_d    = 1'b1;
                pc_out_d   = pc_q;
                inst_out_d = mc_inst_in;
                pc_d       = pc_q + 32'd4;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      pc_out_q   <= 32'h0;
      inst_out_q <= 32'h0;
      line_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      inst_out_q <= inst_out_d;
      if (fill_en) begin
        line_vld_q[idx] <= 1'b1;
      end
    end
  end

  // A fill simply overwrites whatever line sits at idx.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mc_inst_in;
    end
  end

  assign mc_if_req_out    = (state_q == FETCH);
  assign mc_inst_addr_out = pc_q;
  assign if_valid_out     = valid_q;
  assign if_pc_out        = pc_out_q;
  assign if_inst_out      = inst_out_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
//
// A small mem_ctrl responder answers requests a fixed number of request
// cycles after they appear. A behavioural model of the fetch stage tracks
// PC, state and cache contents, pushing each instruction it expects to be
// delivered onto a scoreboard queue; deliveries from the DUT pop and compare.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam int IDX_W = 7;
  localparam int LINES = 1 << IDX_W;
  localparam int LAT   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_tgt = 32'h0;
  logic        done = 1'b0;
  logic [31:0] mc_inst = 32'h0;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch #(
    .ICACHE_IDX_W(IDX_W),
    .RESET_PC    (32'h0)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .rdy_in          (rdy),
    .stall_in        (stall),
    .branch_en_in    (br_en),
    .branch_target_in(br_tgt),
    .mc_if_req_out   (mc_req),
    .mc_inst_addr_out(mc_addr),
    .mc_inst_done_in (done),
    .mc_inst_in      (mc_inst),
    .if_valid_out    (if_valid),
    .if_pc_out       (if_pc),
    .if_inst_out     (if_inst)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_deliv = 0;
  int   req_cnt = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_fetch;
  logic        m_valid;
  logic        m_lv [LINES];
  logic [31:0] m_la [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0513;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_fetch = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < LINES; i++) m_lv[i] = 1'b0;
    sb_q.delete();
    req_cnt = 0;
  endtask

  task automatic model_step();
    logic mstall;
    int   idx;
    mstall = stall && m_valid;
    idx    = int'(m_pc[IDX_W+1:2]);
    if (!rdy) return;
    if (br_en) begin
      m_pc    = br_tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_fetch = 1'b0;
    end else if (!m_fetch) begin
      if (!mstall) begin
        if (m_lv[idx] && m_la[idx] == m_pc) begin
          sb_q.push_back({m_pc, mem_word(m_pc)});
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end else begin
          m_valid = 1'b0;
          m_fetch = 1'b1;
        end
      end
    end else if (done) begin
      m_lv[idx] = 1'b1;
      m_la[idx] = m_pc;
      m_fetch   = 1'b0;
      if (!mstall) begin
        sb_q.push_back({m_pc, mem_word(m_pc)});
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: responder decides done, model advances, DUT is
  // sampled 1 time unit after the edge, deliveries are scoreboarded.
  task automatic tick();
    logic pre_req;
    logic pre_consume;
    exp_t e;
    done    = 1'b0;
    mc_inst = 32'h0;
    if (rdy && mc_req && req_cnt == LAT - 1) begin
      done    = 1'b1;
      mc_inst = mem_word(mc_addr);
    end
    pre_req     = mc_req;
    pre_consume = !(stall && if_valid);
    model_step();
    @(posedge clk);
    #1;
    if (rdy) begin
      if (done || !pre_req || br_en) req_cnt = 0;
      else req_cnt++;
    end
    done = 1'b0;
    n_tests++;
    if (if_valid !== m_valid) begin
      n_fail++;
      $display("FAIL cyc_valid: got %b want %b", if_valid, m_valid);
    end
    n_tests++;
    if (mc_req !== m_fetch) begin
      n_fail++;
      $display("FAIL cyc_req: got %b want %b", mc_req, m_fetch);
    end
    n_tests++;
    if (mc_addr !== m_pc) begin
      n_fail++;
      $display("FAIL cyc_addr: got %h want %h", mc_addr, m_pc);
    end
    if (rdy && !br_en && pre_consume && if_valid) begin
      n_deliv++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL deliver_unexpected: got pc=%h inst=%h want none", if_pc, if_inst);
      end else begin
        e = sb_q.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          n_fail++;
          $display("FAIL deliver: got pc=%h inst=%h want pc=%h inst=%h",
                   if_pc, if_inst, e.pc, e.inst);
        end else begin
          $display("[TB] deliver pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
  endtask

  task automatic wait_deliv(input int bound);
    int target;
    int k;
    target = n_deliv + 1;
    k = 0;
    while (n_deliv < target && k < bound) begin
      tick();
      k++;
    end
    n_tests++;
    if (n_deliv < target) begin
      n_fail++;
      $display("FAIL deliver_timeout: got %0d deliveries want %0d", n_deliv, target);
    end
  endtask

  task automatic branch_to(input logic [31:0] t);
    br_en  = 1'b1;
    br_tgt = t;
    tick();
    br_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (mc_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got req=%b valid=%b want 0 0", mc_req, if_valid);
    end
    n_tests++;
    if (mc_addr !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h pc=%h inst=%h want 0", mc_addr, if_pc, if_inst);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss();
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL cold_req: got req=%b addr=%h want 1 00000000", mc_req, mc_addr);
    end
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0000_0513) begin
      n_fail++;
      $display("FAIL cold_out: got pc=%h inst=%h want 00000000 00000513", if_pc, if_inst);
    end
    wait_deliv(20);
  endtask

  task automatic test_redirect_mid_fetch();
    int k;
    k = 0;
    while (!(mc_req && mc_addr == 32'h8 && req_cnt == LAT - 1) && k < 60) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 60) begin
      n_fail++;
      $display("FAIL redir_reach: got addr=%h req=%b want fetch of 00000008", mc_addr, mc_req);
    end
    branch_to(32'h100);
    n_tests++;
    if (if_valid !== 1'b0 || mc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_drop: got valid=%b req=%b want 0 0", if_valid, mc_req);
    end
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_req: got req=%b addr=%h want 1 00000100", mc_req, mc_addr);
    end
    wait_deliv(20);
  endtask

  task automatic test_hit_and_stall();
    branch_to(32'h0);
    tick();
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || mc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit0: got valid=%b pc=%h req=%b want 1 00000000 0", if_valid, if_pc, mc_req);
    end
    tick();
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || mc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit4: got valid=%b pc=%h req=%b want 1 00000004 0", if_valid, if_pc, mc_req);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== mem_word(32'h4) || mc_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b pc=%h inst=%h addr=%h want 1 00000004 %h 00000008",
                 if_valid, if_pc, if_inst, mc_addr, mem_word(32'h4));
      end
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL line8_discarded: got req=%b addr=%h want 1 00000008", mc_req, mc_addr);
    end
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_release: got pc=%h want 00000008", if_pc);
    end
  endtask

  task automatic test_alias();
    branch_to(32'h200);
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL alias_fill: got pc=%h want 00000200", if_pc);
    end
    branch_to(32'h0);
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL alias_evict: got req=%b addr=%h want 1 00000000", mc_req, mc_addr);
    end
    wait_deliv(20);
  endtask

  task automatic test_freeze();
    branch_to(32'h300);
    tick();
    stall = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h300 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze: got req=%b addr=%h valid=%b want 1 00000300 0", mc_req, mc_addr, if_valid);
      end
    end
    rdy = 1'b1;
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL stall_empty: got pc=%h want 00000300", if_pc);
    end
    tick();
    tick();
    n_tests++;
    if (if_pc !== 32'h300 || mc_addr !== 32'h304 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_full: got pc=%h addr=%h valid=%b want 00000300 00000304 1",
               if_pc, mc_addr, if_valid);
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    branch_to(32'hFFFF_FFFE);
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'hFFFF_FFFC || mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: got pc=%h next=%h want fffffffc 00000000", if_pc, mc_addr);
    end
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: got pc=%h want 00000000", if_pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    branch_to(32'h40);
    tick();
    tick();
    n_tests++;
    if (mc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got req=%b want 1", mc_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mc_req !== 1'b0 || if_valid !== 1'b0 || mc_addr !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: got req=%b valid=%b addr=%h pc=%h inst=%h want all 0",
               mc_req, if_valid, mc_addr, if_pc, if_inst);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_cleared: got req=%b addr=%h want 1 00000000", mc_req, mc_addr);
    end
    wait_deliv(20);
    n_tests++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0000_0513) begin
      n_fail++;
      $display("FAIL rst_refetch: got pc=%h inst=%h want 00000000 00000513", if_pc, if_inst);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_redirect_mid_fetch();
    test_hit_and_stall();
    test_alias();
    test_freeze();
    test_wrap();
    test_reset_mid_fetch();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
